dec_select_seq: RTL

// - Upstream stage of the 7-segment decoder: generates the 2-bit select {s1,s0} that drives the decoder's s1/s0 inputs.
// - Steps the select on a debounced push-button press, or automatically every TICK_DIV clocks when auto_en=1.
// - Value walks 0..MAX_VAL and wraps; direction set by dir.

---
 rtl/dec_pkg.sv | 35 +++
 rtl/btn_debounce.sv | 60 ++++++
 rtl/dec_select_seq.sv | 75 +++++++
 3 files changed

// File: rtl/dec_pkg.sv
// Shared types and constants for the 7-segment select sequencer.
// Select width, select codes, direction codes and the wrap helper.
package dec_pkg;

  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_1 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_2 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_3 = 2'd3;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Next select value with wrap at max.
  // Out-of-range values recover: up goes to 0,
  // down goes to max.
  function automatic logic [SEL_W-1:0] sel_next(
    input logic [SEL_W-1:0] cur,
    input logic             up,
    input logic [SEL_W-1:0] max
  );
    logic [SEL_W-1:0] nxt;
    nxt = cur;
    if (up == DIR_UP) begin
      if (cur >= max) nxt = SEL_0;
      else            nxt = cur + 1'b1;
    end else begin
      if (cur == SEL_0 || cur > max) nxt = max;
      else                           nxt = cur - 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop sync, counter debounce, rise pulse.
// Ports: clk, rst_n, btn_raw in; btn_level, btn_rise (1 clk) out.
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int CW =
    (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Any sample agreeing with the accepted level
  // restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      btn_level <= 1'b0;
    end else if (sync2 == btn_level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt       <= '0;
      btn_level <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered edge so the pulse is a clean flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d  <= 1'b0;
      btn_rise <= 1'b0;
    end else begin
      level_d  <= btn_level;
      btn_rise <= btn_level & ~level_d;
    end
  end

endmodule

// File: rtl/dec_select_seq.sv
// Select sequencer for the 7-segment decoder: steps {s1,s0} on press/tick.
// Ports: clk, rst_n, btn_step, dir, auto_en in; s0, s1, step_pulse out.
module dec_select_seq
  import dec_pkg::*;
#(
  parameter int DEB_CYCLES = 250000,
  parameter int TICK_DIV   = 50000000,
  parameter int MAX_VAL    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_step,
  input  logic dir,
  input  logic auto_en,
  output logic s0,
  output logic s1,
  output logic step_pulse
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST =
    PW'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0] MAXV =
    SEL_W'(MAX_VAL);

  logic             btn_level;
  logic             btn_rise;
  logic [PW-1:0]    pre;
  logic             tick;
  logic             press;
  logic             req;
  logic [SEL_W-1:0] sel;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_step),
    .btn_level(btn_level),
    .btn_rise (btn_rise)
  );

  // A rise only counts while the level is still high.
  // Press and tick merge into one request, so a
  // coincident pair yields a single step.
  always_comb begin
    tick  = auto_en && (pre == PRE_LAST);
    press = btn_rise & btn_level;
    req   = press | tick;
  end

  // Held at 0 while disabled: re-enable gives a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pre <= '0;
    else if (!auto_en) pre <= '0;
    else if (tick)    pre <= '0;
    else              pre <= pre + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= SEL_0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= req;
      if (req) sel <= sel_next(sel, dir, MAXV);
    end
  end

  assign s0 = sel[0];
  assign s1 = sel[1];

endmodule
